// File: rtl/hilo_issue_queue_if.sv
// rtl/hilo_issue_queue_if.sv - dispatch/enqueue and HI/LO-unit issue bundle for hilo_issue_queue
`ifndef INST_STATE_WD
`define INST_STATE_WD 8
`endif

interface hilo_issue_queue_if #(
    parameter int ST_WD  = `INST_STATE_WD,
    parameter int TAG_WD = 6
);
    logic              enq_valid;
    logic              enq_ready;
    logic [11:0]       enq_op;
    logic [ST_WD-1:0]  enq_status;
    logic              enq_src1_rdy;
    logic [TAG_WD-1:0] enq_src1_tag;
    logic [31:0]       enq_src1;
    logic              enq_hilo_rdy;
    logic [63:0]       enq_hilo;
    logic              fu_busy;
    logic              issue;
    logic [11:0]       iss_op;
    logic [ST_WD-1:0]  iss_status;
    logic [31:0]       iss_rdata1;
    logic [63:0]       iss_rdata2;

    modport master (
        output enq_valid, enq_op, enq_status, enq_src1_rdy, enq_src1_tag, enq_src1,
               enq_hilo_rdy, enq_hilo, fu_busy,
        input  enq_ready, issue, iss_op, iss_status, iss_rdata1, iss_rdata2
    );

    modport slave (
        input  enq_valid, enq_op, enq_status, enq_src1_rdy, enq_src1_tag, enq_src1,
               enq_hilo_rdy, enq_hilo, fu_busy,
        output enq_ready, issue, iss_op, iss_status, iss_rdata1, iss_rdata2
    );
endinterface

// File: rtl/hilo_issue_queue.sv
// rtl/hilo_issue_queue.sv - in-order issue queue feeding the HI/LO unit; HILO_IQ_BYPASS_EN enables wakeup-to-issue bypass
`ifndef INST_STATE_WD
`define INST_STATE_WD 8
`endif

module hilo_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int ST_WD  = `INST_STATE_WD,
    parameter int TAG_WD = 6
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    hilo_issue_queue_if.slave        q,
    input  logic                     cdb_valid,
    input  logic [TAG_WD-1:0]        cdb_tag,
    input  logic [31:0]              cdb_data,
    input  logic                     hilo_wb_valid,
    input  logic [63:0]              hilo_wb_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  s1_rdy_q;
    logic [DEPTH-1:0]  hl_rdy_q;
    logic [11:0]       op_q  [DEPTH];
    logic [ST_WD-1:0]  st_q  [DEPTH];
    logic [TAG_WD-1:0] tag_q [DEPTH];
    logic [31:0]       s1_q  [DEPTH];
    logic [63:0]       hl_q  [DEPTH];
    logic [PW-1:0]     head_q;
    logic [PW-1:0]     tail_q;
    logic [CW-1:0]     count_q;

    logic        do_enq;
    logic        do_iss;
    logic        enq_cdb_hit;
    logic        head_s1_rdy;
    logic        head_hl_rdy;
    logic [31:0] head_s1;
    logic [63:0] head_hl;

    assign q.enq_ready  = (count_q != CW'(DEPTH)) & ~flush;
    assign do_enq       = q.enq_valid & q.enq_ready;
    assign enq_cdb_hit  = cdb_valid & ~q.enq_src1_rdy & (q.enq_src1_tag == cdb_tag);

`ifdef HILO_IQ_BYPASS_EN
    // Head may consume an operand straight off the wakeup bus in the cycle it arrives.
    logic head_cdb_hit;
    assign head_cdb_hit = cdb_valid & ~s1_rdy_q[head_q] & (tag_q[head_q] == cdb_tag);
    assign head_s1_rdy  = s1_rdy_q[head_q] | head_cdb_hit;
    assign head_hl_rdy  = hl_rdy_q[head_q] | hilo_wb_valid;
    assign head_s1      = s1_rdy_q[head_q] ? s1_q[head_q] : cdb_data;
    assign head_hl      = hl_rdy_q[head_q] ? hl_q[head_q] : hilo_wb_data;
`else
    assign head_s1_rdy  = s1_rdy_q[head_q];
    assign head_hl_rdy  = hl_rdy_q[head_q];
    assign head_s1      = s1_q[head_q];
    assign head_hl      = hl_q[head_q];
`endif

    assign do_iss       = valid_q[head_q] & head_s1_rdy & head_hl_rdy & ~q.fu_busy & ~flush;
    assign q.issue      = do_iss;
    assign q.iss_op     = do_iss ? op_q[head_q] : '0;
    assign q.iss_status = do_iss ? st_q[head_q] : '0;
    assign q.iss_rdata1 = do_iss ? head_s1 : '0;
    assign q.iss_rdata2 = do_iss ? head_hl : '0;
    assign count        = count_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q  <= '0;
            s1_rdy_q <= '0;
            hl_rdy_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]  <= '0;
                st_q[i]  <= '0;
                tag_q[i] <= '0;
                s1_q[i]  <= '0;
                hl_q[i]  <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && !s1_rdy_q[i] && cdb_valid && (tag_q[i] == cdb_tag)) begin
                    s1_rdy_q[i] <= 1'b1;
                    s1_q[i]     <= cdb_data;
                end
                if (valid_q[i] && !hl_rdy_q[i] && hilo_wb_valid) begin
                    hl_rdy_q[i] <= 1'b1;
                    hl_q[i]     <= hilo_wb_data;
                end
            end
            // Tail slot is never valid while enq_ready, so this cannot collide with the wakeup loop.
            if (do_enq) begin
                valid_q[tail_q]  <= 1'b1;
                op_q[tail_q]     <= q.enq_op;
                st_q[tail_q]     <= q.enq_status;
                tag_q[tail_q]    <= q.enq_src1_tag;
                s1_rdy_q[tail_q] <= q.enq_src1_rdy | enq_cdb_hit;
                s1_q[tail_q]     <= enq_cdb_hit ? cdb_data : q.enq_src1;
                hl_rdy_q[tail_q] <= q.enq_hilo_rdy | hilo_wb_valid;
                hl_q[tail_q]     <= (!q.enq_hilo_rdy && hilo_wb_valid) ? hilo_wb_data : q.enq_hilo;
                tail_q           <= tail_q + 1'b1;
            end
            if (do_iss) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            count_q <= count_q + CW'(do_enq) - CW'(do_iss);
        end
    end
endmodule
